// File: rtl/ttt_game_sequencer.sv
// Tic-tac-toe move sequencer: accepts placements, scans the eight lines one per
// cycle after each move, and reports the winner, a draw, or the next player's turn.
module ttt_game_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  square,
    input  logic        place,
    input  logic        new_game,
    output logic [17:0] board,
    output logic        turn,
    output logic        busy,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic [2:0]  win_line,
    output logic [3:0]  move_count,
    output logic        place_ack,
    output logic        place_err
);

    typedef enum logic [1:0] {PLAY, CHECK, OVER} state_t;

    state_t      state_q, state_d;
    logic [17:0] board_q, board_d;
    logic        turn_q, turn_d;
    logic [3:0]  mc_q, mc_d;
    logic [1:0]  winner_q, winner_d;
    logic [2:0]  win_line_q, win_line_d;
    logic [2:0]  line_q, line_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        over_q, over_d;
    logic        place_q;

    logic        place_edge;
    logic [1:0]  mover;

    function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
        logic [1:0] c;
        c = 2'b00;
        for (int k = 0; k < 9; k++) begin
            if (idx == 4'(k)) c = b[2*k +: 2];
        end
        return c;
    endfunction

    // Three cell indices of a line, packed {first, second, third}.
    function automatic logic [11:0] line_cells(input logic [2:0] li);
        logic [11:0] r;
        case (li)
            3'd0:    r = {4'd0, 4'd1, 4'd2};
            3'd1:    r = {4'd3, 4'd4, 4'd5};
            3'd2:    r = {4'd6, 4'd7, 4'd8};
            3'd3:    r = {4'd0, 4'd3, 4'd6};
            3'd4:    r = {4'd1, 4'd4, 4'd7};
            3'd5:    r = {4'd2, 4'd5, 4'd8};
            3'd6:    r = {4'd0, 4'd4, 4'd8};
            default: r = {4'd2, 4'd4, 4'd6};
        endcase
        return r;
    endfunction

    function automatic logic line_won(input logic [17:0] b, input logic [2:0] li,
                                      input logic [1:0] code);
        logic [11:0] c;
        c = line_cells(li);
        return (cell_at(b, c[11:8]) == code) && (cell_at(b, c[7:4]) == code) &&
               (cell_at(b, c[3:0]) == code);
    endfunction

    assign place_edge = place & ~place_q;
    assign mover      = turn_q ? 2'b10 : 2'b01;

    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        turn_d     = turn_q;
        mc_d       = mc_q;
        winner_d   = winner_q;
        win_line_d = win_line_q;
        line_d     = line_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;

        if (new_game) begin
            state_d    = PLAY;
            board_d    = '0;
            turn_d     = 1'b0;
            mc_d       = '0;
            winner_d   = 2'b00;
            win_line_d = '0;
            line_d     = '0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (place_edge) begin
                        if (square <= 4'd8 && cell_at(board_q, square) == 2'b00) begin
                            for (int k = 0; k < 9; k++) begin
                                if (square == 4'(k)) board_d[2*k +: 2] = mover;
                            end
                            mc_d    = (mc_q == 4'd9) ? 4'd9 : mc_q + 4'd1;
                            ack_d   = 1'b1;
                            line_d  = '0;
                            state_d = CHECK;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                CHECK: begin
                    // Edges arriving here are dropped: place_q still tracks place.
                    if (line_won(board_q, line_q, mover)) begin
                        winner_d   = mover;
                        win_line_d = line_q;
                        state_d    = OVER;
                    end else if (line_q == 3'd7) begin
                        if (mc_q == 4'd9) begin
                            winner_d = 2'b11;
                            state_d  = OVER;
                        end else begin
                            turn_d  = ~turn_q;
                            state_d = PLAY;
                        end
                    end else begin
                        line_d = line_q + 3'd1;
                    end
                end
                OVER: begin
                    if (place_edge) err_d = 1'b1;
                end
                default: state_d = PLAY;
            endcase
        end

        busy_d = (state_d == CHECK);
        over_d = (state_d == OVER);
    end

    // place_q resets high so a place held through reset is not seen as an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= PLAY;
            board_q    <= '0;
            turn_q     <= 1'b0;
            mc_q       <= '0;
            winner_q   <= 2'b00;
            win_line_q <= '0;
            line_q     <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            over_q     <= 1'b0;
            place_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            board_q    <= board_d;
            turn_q     <= turn_d;
            mc_q       <= mc_d;
            winner_q   <= winner_d;
            win_line_q <= win_line_d;
            line_q     <= line_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            over_q     <= over_d;
            place_q    <= place;
        end
    end

    assign board      = board_q;
    assign turn       = turn_q;
    assign busy       = busy_q;
    assign game_over  = over_q;
    assign winner     = winner_q;
    assign win_line   = win_line_q;
    assign move_count = mc_q;
    assign place_ack  = ack_q;
    assign place_err  = err_q;

endmodule

// File: tb/tb_ttt_game_sequencer.sv
// Directed bench for ttt_game_sequencer: a move table covering three full games,
// then hand-written sequences for held place, busy edges, new_game and reset.
module tb_ttt_game_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  square;
    logic        place;
    logic        new_game;
    logic [17:0] board;
    logic        turn, busy, game_over, place_ack, place_err;
    logic [1:0]  winner;
    logic [2:0]  win_line;
    logic [3:0]  move_count;

    int errors = 0;
    int checks = 0;

    ttt_game_sequencer dut (
        .clk(clk), .rst(rst), .square(square), .place(place), .new_game(new_game),
        .board(board), .turn(turn), .busy(busy), .game_over(game_over),
        .winner(winner), .win_line(win_line), .move_count(move_count),
        .place_ack(place_ack), .place_err(place_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200us");
        $fatal(1);
    end

    typedef struct {
        logic        ng;
        logic [3:0]  sq;
        logic        ack;
        logic        err;
        logic [17:0] brd;
        logic        trn;
        logic [3:0]  mc;
        int          lat;
        logic        ovr;
        logic [1:0]  win;
        logic [2:0]  wl;
    } vec_t;

    vec_t tbl [0:22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        place    = 1'b0;
        step();
        new_game = 1'b0;
        chk("newgame board", 32'(board), 32'h0);
        chk("newgame over", 32'(game_over), 32'h0);
    endtask

    initial begin
        int n, acks, errs;

        // ng sq ack err board turn mc lat over win wl
        tbl[0]  = '{1, 15, 0, 1, 18'h00000, 0, 0, 0, 0, 2'b00, 0};
        tbl[1]  = '{0,  0, 1, 0, 18'h00001, 1, 1, 8, 0, 2'b00, 0};
        tbl[2]  = '{0,  0, 0, 1, 18'h00001, 1, 1, 0, 0, 2'b00, 0};
        tbl[3]  = '{0,  3, 1, 0, 18'h00081, 0, 2, 8, 0, 2'b00, 0};
        tbl[4]  = '{0,  1, 1, 0, 18'h00085, 1, 3, 8, 0, 2'b00, 0};
        tbl[5]  = '{0,  4, 1, 0, 18'h00285, 0, 4, 8, 0, 2'b00, 0};
        tbl[6]  = '{0,  2, 1, 0, 18'h00295, 0, 5, 1, 1, 2'b01, 0};
        tbl[7]  = '{0,  5, 0, 1, 18'h00295, 0, 5, 0, 1, 2'b01, 0};
        tbl[8]  = '{1,  1, 1, 0, 18'h00004, 1, 1, 8, 0, 2'b00, 0};
        tbl[9]  = '{0,  0, 1, 0, 18'h00006, 0, 2, 8, 0, 2'b00, 0};
        tbl[10] = '{0,  2, 1, 0, 18'h00016, 1, 3, 8, 0, 2'b00, 0};
        tbl[11] = '{0,  4, 1, 0, 18'h00216, 0, 4, 8, 0, 2'b00, 0};
        tbl[12] = '{0,  5, 1, 0, 18'h00616, 1, 5, 8, 0, 2'b00, 0};
        tbl[13] = '{0,  8, 1, 0, 18'h20616, 1, 6, 7, 1, 2'b10, 6};
        tbl[14] = '{1,  0, 1, 0, 18'h00001, 1, 1, 8, 0, 2'b00, 0};
        tbl[15] = '{0,  1, 1, 0, 18'h00009, 0, 2, 8, 0, 2'b00, 0};
        tbl[16] = '{0,  2, 1, 0, 18'h00019, 1, 3, 8, 0, 2'b00, 0};
        tbl[17] = '{0,  4, 1, 0, 18'h00219, 0, 4, 8, 0, 2'b00, 0};
        tbl[18] = '{0,  3, 1, 0, 18'h00259, 1, 5, 8, 0, 2'b00, 0};
        tbl[19] = '{0,  5, 1, 0, 18'h00A59, 0, 6, 8, 0, 2'b00, 0};
        tbl[20] = '{0,  7, 1, 0, 18'h04A59, 1, 7, 8, 0, 2'b00, 0};
        tbl[21] = '{0,  6, 1, 0, 18'h06A59, 0, 8, 8, 0, 2'b00, 0};
        tbl[22] = '{0,  8, 1, 0, 18'h16A59, 0, 9, 8, 1, 2'b11, 0};

        // Reset with place held high
        rst = 1'b0; place = 1'b1; new_game = 1'b0; square = 4'd0;
        #12;
        chk("reset board", 32'(board), 32'h0);
        chk("reset turn", 32'(turn), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset over", 32'(game_over), 32'h0);
        chk("reset winner", 32'(winner), 32'h0);
        chk("reset win_line", 32'(win_line), 32'h0);
        chk("reset move_count", 32'(move_count), 32'h0);
        chk("reset ack", 32'(place_ack), 32'h0);
        chk("reset err", 32'(place_err), 32'h0);
        rst = 1'b1;
        acks = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            acks += int'(place_ack) + int'(place_err);
        end
        chk("held-through-reset actions", 32'(acks), 32'h0);
        chk("held-through-reset board", 32'(board), 32'h0);
        place = 1'b0;
        step();

        for (int i = 0; i < 23; i++) begin
            if (tbl[i].ng) do_new_game();
            square = tbl[i].sq;
            place  = 1'b1;
            step();
            chk($sformatf("row%0d ack", i), 32'(place_ack), 32'(tbl[i].ack));
            chk($sformatf("row%0d err", i), 32'(place_err), 32'(tbl[i].err));
            chk($sformatf("row%0d board", i), 32'(board), 32'(tbl[i].brd));
            place = 1'b0;
            if (tbl[i].ack) begin
                n = 0;
                while (busy && n < 20) begin
                    step();
                    n++;
                end
                chk($sformatf("row%0d latency", i), 32'(n), 32'(tbl[i].lat));
            end else begin
                step();
                chk($sformatf("row%0d pulse", i), 32'({place_ack, place_err}), 32'h0);
            end
            chk($sformatf("row%0d turn", i), 32'(turn), 32'(tbl[i].trn));
            chk($sformatf("row%0d move_count", i), 32'(move_count), 32'(tbl[i].mc));
            chk($sformatf("row%0d game_over", i), 32'(game_over), 32'(tbl[i].ovr));
            chk($sformatf("row%0d winner", i), 32'(winner), 32'(tbl[i].win));
            if (tbl[i].win == 2'b01 || tbl[i].win == 2'b10)
                chk($sformatf("row%0d win_line", i), 32'(win_line), 32'(tbl[i].wl));
        end

        // Place held for 5 cycles on an invalid square: one err only
        do_new_game();
        square = 4'd15; place = 1'b1;
        acks = 0; errs = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            acks += int'(place_ack);
            errs += int'(place_err);
        end
        place = 1'b0;
        step();
        chk("held place errs", 32'(errs), 32'h1);
        chk("held place acks", 32'(acks), 32'h0);

        // Place edge while busy is ignored and not queued
        square = 4'd4; place = 1'b1;
        step();
        chk("busy-edge first ack", 32'(place_ack), 32'h1);
        place = 1'b0;
        step();
        step();
        square = 4'd0; place = 1'b1;
        acks = 0; errs = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            acks += int'(place_ack);
            errs += int'(place_err);
        end
        chk("busy-edge acks", 32'(acks), 32'h0);
        chk("busy-edge errs", 32'(errs), 32'h0);
        chk("busy-edge board", 32'(board), 32'h00100);
        chk("busy-edge turn", 32'(turn), 32'h1);
        place = 1'b0;
        step();

        // new_game with simultaneous place edge mid-CHECK
        square = 4'd0; place = 1'b1;
        step();
        chk("ng-mid ack", 32'(place_ack), 32'h1);
        place = 1'b0;
        step();
        step();
        new_game = 1'b1; place = 1'b1; square = 4'd8;
        step();
        chk("ng-mid board", 32'(board), 32'h0);
        chk("ng-mid busy", 32'(busy), 32'h0);
        chk("ng-mid over", 32'(game_over), 32'h0);
        chk("ng-mid turn", 32'(turn), 32'h0);
        chk("ng-mid move_count", 32'(move_count), 32'h0);
        chk("ng-mid ack/err", 32'({place_ack, place_err}), 32'h0);
        new_game = 1'b0; place = 1'b0;
        step();
        chk("ng-mid after busy", 32'(busy), 32'h0);

        // Short async reset pulse mid-CHECK, place held across release
        square = 4'd2; place = 1'b1;
        step();
        chk("rst-mid ack", 32'(place_ack), 32'h1);
        place = 1'b0;
        step();
        step();
        chk("rst-mid busy before", 32'(busy), 32'h1);
        place = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("rst-mid board", 32'(board), 32'h0);
        chk("rst-mid busy", 32'(busy), 32'h0);
        chk("rst-mid move_count", 32'(move_count), 32'h0);
        chk("rst-mid turn/over/win", 32'({turn, game_over, winner}), 32'h0);
        #1 rst = 1'b1;
        acks = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            acks += int'(place_ack) + int'(place_err);
        end
        chk("rst-mid held place actions", 32'(acks), 32'h0);
        chk("rst-mid board after", 32'(board), 32'h0);
        chk("rst-mid busy after", 32'(busy), 32'h0);
        place = 1'b0;
        step();
        place = 1'b1;
        step();
        chk("post-reset ack", 32'(place_ack), 32'h1);
        chk("post-reset board", 32'(board), 32'h00010);
        place = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
